// File: rtl/cpu_mem_arbiter_if.sv
// cpu_mem_arbiter_if: fetch, data and controller-side signals
// seen by the fetch/data arbiter in front of cpu_mem_controller.
interface cpu_mem_arbiter_if;
    // instruction-fetch requester
    logic        i_if_stb;
    logic [31:0] i_if_addr;
    logic [31:0] o_if_data;
    logic        o_if_ack;
    logic        o_if_stall;

    // load/store requester
    logic        i_d_stb;
    logic        i_d_we;
    logic [31:0] i_d_addr;
    logic [31:0] i_d_data;
    logic [2:0]  i_d_sel;
    logic [31:0] o_d_data;
    logic        o_d_ack;
    logic        o_d_stall;

    // memory controller side
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [31:0] o_wb_addr;
    logic [31:0] o_wb_data;
    logic [2:0]  o_sel;
    logic [31:0] i_wb_data;
    logic        i_wb_ack;
    logic        i_wb_stall;

    // arbiter view
    modport slave (
        input  i_if_stb, i_if_addr,
        output o_if_data, o_if_ack, o_if_stall,
        input  i_d_stb, i_d_we, i_d_addr, i_d_data, i_d_sel,
        output o_d_data, o_d_ack, o_d_stall,
        output o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_sel,
        input  i_wb_data, i_wb_ack, i_wb_stall
    );

    // core + controller view
    modport master (
        output i_if_stb, i_if_addr,
        input  o_if_data, o_if_ack, o_if_stall,
        output i_d_stb, i_d_we, i_d_addr, i_d_data, i_d_sel,
        input  o_d_data, o_d_ack, o_d_stall,
        input  o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_sel,
        output i_wb_data, i_wb_ack, i_wb_stall
    );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: shares one memory controller port between
// instruction fetch and load/store, round-robin on contention.
module cpu_mem_arbiter (
    input  logic             i_clk,
    input  logic             i_reset,
    cpu_mem_arbiter_if.slave bus
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_D  = 1'b1;

    localparam logic [2:0] SEL_WORD = 3'b010;

    logic [0:0]  state;
    logic        grant;
    logic        last_grant;

    logic        if_pend;
    logic [31:0] if_addr_q;

    logic        d_pend;
    logic        d_we_q;
    logic [31:0] d_addr_q;
    logic [31:0] d_data_q;
    logic [2:0]  d_sel_q;

    logic        if_cap;
    logic        d_cap;
    logic        pick_d;
    logic        issue;
    logic        done;
    logic        done_if;
    logic        done_d;

    // A slot is busy exactly while it holds a request.
    assign bus.o_if_stall = if_pend;
    assign bus.o_d_stall  = d_pend;

    assign if_cap = bus.i_if_stb && !if_pend;
    assign d_cap  = bus.i_d_stb && !d_pend;

    // Data wins when it is alone, or when fetch was served last.
    assign pick_d = d_pend && (!if_pend || (last_grant == GNT_IF));

    assign issue = (state == IDLE) && (if_pend || d_pend)
                   && !bus.i_wb_stall;

    assign done    = (state == WAIT) && bus.i_wb_ack;
    assign done_if = done && (grant == GNT_IF);
    assign done_d  = done && (grant == GNT_D);

    // Fetch slot: capture when free, release on its completion.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            if_pend   <= 1'b0;
            if_addr_q <= 32'h0;
        end else if (if_cap) begin
            if_pend   <= 1'b1;
            if_addr_q <= bus.i_if_addr;
        end else if (done_if) begin
            if_pend   <= 1'b0;
        end
    end

    // Data slot: capture when free, release on its completion.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            d_pend   <= 1'b0;
            d_we_q   <= 1'b0;
            d_addr_q <= 32'h0;
            d_data_q <= 32'h0;
            d_sel_q  <= SEL_WORD;
        end else if (d_cap) begin
            d_pend   <= 1'b1;
            d_we_q   <= bus.i_d_we;
            d_addr_q <= bus.i_d_addr;
            d_data_q <= bus.i_d_data;
            d_sel_q  <= bus.i_d_sel;
        end else if (done_d) begin
            d_pend   <= 1'b0;
        end
    end

    // Issue one transaction, wait for its ack, return it to the winner.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            grant      <= GNT_D;
            last_grant <= GNT_D;
            bus.o_wb_stb  <= 1'b0;
            bus.o_wb_we   <= 1'b0;
            bus.o_wb_addr <= 32'hFFFF_FFFF;
            bus.o_wb_data <= 32'hFFFF_FFFF;
            bus.o_sel     <= SEL_WORD;
            bus.o_if_ack  <= 1'b0;
            bus.o_if_data <= 32'hFFFF_FFFF;
            bus.o_d_ack   <= 1'b0;
            bus.o_d_data  <= 32'hFFFF_FFFF;
        end else begin
            bus.o_if_ack <= 1'b0;
            bus.o_d_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    bus.o_wb_stb <= 1'b0;
                    if (issue) begin
                        bus.o_wb_stb <= 1'b1;
                        grant        <= pick_d;
                        last_grant   <= pick_d;
                        state        <= WAIT;
                        if (pick_d) begin
                            bus.o_wb_we   <= d_we_q;
                            bus.o_wb_addr <= d_addr_q;
                            bus.o_wb_data <= d_data_q;
                            bus.o_sel     <= d_sel_q;
                        end else begin
                            bus.o_wb_we   <= 1'b0;
                            bus.o_wb_addr <= if_addr_q;
                            bus.o_sel     <= SEL_WORD;
                        end
                    end
                end
                WAIT: begin
                    bus.o_wb_stb <= 1'b0;
                    if (bus.i_wb_ack) begin
                        state <= IDLE;
                        if (grant == GNT_D) begin
                            bus.o_d_ack  <= 1'b1;
                            bus.o_d_data <= bus.i_wb_data;
                        end else begin
                            bus.o_if_ack  <= 1'b1;
                            bus.o_if_data <= bus.i_wb_data;
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    bus.o_wb_stb <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb_cpu_mem_arbiter: directed checks of capture, arbitration,
// controller stall and reset-in-flight for cpu_mem_arbiter.
module tb_cpu_mem_arbiter;

    logic i_clk = 1'b0;
    logic i_reset = 1'b1;

    int checks = 0;
    int errors = 0;
    int if_acks = 0;
    int d_acks = 0;

    cpu_mem_arbiter_if bus ();

    cpu_mem_arbiter dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    // free-running clock
    always #5 i_clk = ~i_clk;

    // count delivered acknowledge pulses per port
    always @(posedge i_clk) begin
        if (bus.o_if_ack === 1'b1) if_acks++;
        if (bus.o_d_ack === 1'b1) d_acks++;
    end

    // hard time limit
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait for the strobe, check its fields, ack it, check the port ack.
    task automatic serve(input string tag, input bit is_d,
                         input logic [31:0] addr, input logic we,
                         input logic [2:0] sel, input logic [31:0] rdata,
                         output int waited);
        bit ok;
        ok = 1'b0;
        waited = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.o_wb_stb === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
            waited++;
        end
        chk({tag, " stb"}, 32'(ok), 32'd1);
        if (ok) begin
            chk({tag, " addr"}, bus.o_wb_addr, addr);
            chk({tag, " we"}, 32'(bus.o_wb_we), 32'(we));
            chk({tag, " sel"}, 32'(bus.o_sel), 32'(sel));
            tick();
            chk({tag, " stb one cycle"}, 32'(bus.o_wb_stb), 32'd0);
            chk({tag, " stall in wait"},
                32'(is_d ? bus.o_d_stall : bus.o_if_stall), 32'd1);
            bus.i_wb_data = rdata;
            bus.i_wb_ack = 1'b1;
            tick();
            bus.i_wb_ack = 1'b0;
            bus.i_wb_data = 32'hFFFF_FFFF;
            if (is_d) begin
                chk({tag, " d_ack"}, 32'(bus.o_d_ack), 32'd1);
                chk({tag, " if_ack quiet"}, 32'(bus.o_if_ack), 32'd0);
                chk({tag, " d_data"}, bus.o_d_data, rdata);
                chk({tag, " d_stall clr"}, 32'(bus.o_d_stall), 32'd0);
            end else begin
                chk({tag, " if_ack"}, 32'(bus.o_if_ack), 32'd1);
                chk({tag, " d_ack quiet"}, 32'(bus.o_d_ack), 32'd0);
                chk({tag, " if_data"}, bus.o_if_data, rdata);
                chk({tag, " if_stall clr"}, 32'(bus.o_if_stall), 32'd0);
            end
        end
    endtask

    initial begin
        int w;
        logic [31:0] fa;
        logic [31:0] da;
        bit exp_d;

        bus.i_if_stb = 1'b0;
        bus.i_if_addr = 32'h0;
        bus.i_d_stb = 1'b0;
        bus.i_d_we = 1'b0;
        bus.i_d_addr = 32'h0;
        bus.i_d_data = 32'h0;
        bus.i_d_sel = 3'b010;
        bus.i_wb_data = 32'h0;
        bus.i_wb_ack = 1'b0;
        bus.i_wb_stall = 1'b0;

        // reset values
        i_reset = 1'b1;
        tick();
        tick();
        chk("rst wb_stb", 32'(bus.o_wb_stb), 32'd0);
        chk("rst wb_we", 32'(bus.o_wb_we), 32'd0);
        chk("rst wb_addr", bus.o_wb_addr, 32'hFFFF_FFFF);
        chk("rst wb_data", bus.o_wb_data, 32'hFFFF_FFFF);
        chk("rst sel", 32'(bus.o_sel), 32'd2);
        chk("rst if_data", bus.o_if_data, 32'hFFFF_FFFF);
        chk("rst d_data", bus.o_d_data, 32'hFFFF_FFFF);
        chk("rst acks", {30'd0, bus.o_if_ack, bus.o_d_ack}, 32'd0);
        chk("rst stalls", {30'd0, bus.o_if_stall, bus.o_d_stall}, 32'd0);
        i_reset = 1'b0;
        tick();

        // single fetch, two-cycle issue latency
        bus.i_if_stb = 1'b1;
        bus.i_if_addr = 32'h100;
        tick();
        bus.i_if_stb = 1'b0;
        chk("f1 if_stall set", 32'(bus.o_if_stall), 32'd1);
        serve("f1", 1'b0, 32'h100, 1'b0, 3'b010, 32'h0000_0013, w);
        chk("f1 latency", 32'(w), 32'd1);
        tick();
        chk("f1 ack one cycle", 32'(bus.o_if_ack), 32'd0);
        chk("f1 no d_ack", 32'(d_acks), 32'd0);

        // store byte
        bus.i_d_stb = 1'b1;
        bus.i_d_we = 1'b1;
        bus.i_d_addr = 32'h203;
        bus.i_d_data = 32'h0000_00AB;
        bus.i_d_sel = 3'b000;
        tick();
        bus.i_d_stb = 1'b0;
        chk("sb d_stall set", 32'(bus.o_d_stall), 32'd1);
        tick();
        chk("sb wb_data", bus.o_wb_data, 32'h0000_00AB);
        serve("sb", 1'b1, 32'h203, 1'b1, 3'b000, 32'h0000_0055, w);
        tick();

        // contention: fetch first, data only after the fetch ack
        bus.i_if_stb = 1'b1;
        bus.i_if_addr = 32'h104;
        bus.i_d_stb = 1'b1;
        bus.i_d_we = 1'b0;
        bus.i_d_addr = 32'h208;
        bus.i_d_sel = 3'b010;
        tick();
        bus.i_if_stb = 1'b0;
        bus.i_d_stb = 1'b0;
        serve("ct f", 1'b0, 32'h104, 1'b0, 3'b010, 32'h1111_1111, w);
        chk("ct d still stalled", 32'(bus.o_d_stall), 32'd1);
        serve("ct d", 1'b1, 32'h208, 1'b0, 3'b010, 32'h2222_2222, w);
        chk("ct d after ack", 32'(w), 32'd1);
        tick();

        // saturation: both re-strobe on each ack, grants alternate
        fa = 32'h400;
        da = 32'h500;
        bus.i_if_stb = 1'b1;
        bus.i_if_addr = fa;
        bus.i_d_stb = 1'b1;
        bus.i_d_addr = da;
        tick();
        bus.i_if_stb = 1'b0;
        bus.i_d_stb = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp_d = k[0];
            serve($sformatf("sat%0d", k), exp_d, exp_d ? da : fa,
                  1'b0, 3'b010, 32'hA0 + 32'(k), w);
            chk($sformatf("sat%0d wait", k), 32'(w),
                (k == 0 || k == 7) ? 32'd1 : 32'd0);
            if (k < 6) begin
                if (exp_d) begin
                    da = da + 32'd4;
                    bus.i_d_stb = 1'b1;
                    bus.i_d_addr = da;
                end else begin
                    fa = fa + 32'd4;
                    bus.i_if_stb = 1'b1;
                    bus.i_if_addr = fa;
                end
                tick();
                bus.i_if_stb = 1'b0;
                bus.i_d_stb = 1'b0;
            end
        end
        tick();
        chk("sat idle stalls", {30'd0, bus.o_if_stall, bus.o_d_stall}, 32'd0);

        // controller busy holds off the strobe
        bus.i_wb_stall = 1'b1;
        bus.i_if_stb = 1'b1;
        bus.i_if_addr = 32'h600;
        tick();
        bus.i_if_stb = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("busy%0d no stb", i), 32'(bus.o_wb_stb), 32'd0);
        end
        bus.i_wb_stall = 1'b0;
        serve("busy", 1'b0, 32'h600, 1'b0, 3'b010, 32'h6666_6666, w);
        tick();

        // reset while waiting, then a stale ack
        bus.i_d_stb = 1'b1;
        bus.i_d_we = 1'b0;
        bus.i_d_addr = 32'h700;
        bus.i_d_sel = 3'b101;
        tick();
        bus.i_d_stb = 1'b0;
        tick();
        chk("rw stb", 32'(bus.o_wb_stb), 32'd1);
        tick();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        chk("rw stalls clr", {30'd0, bus.o_if_stall, bus.o_d_stall}, 32'd0);
        bus.i_wb_ack = 1'b1;
        bus.i_wb_data = 32'h0000_DEAD;
        tick();
        bus.i_wb_ack = 1'b0;
        chk("rw stale no ack", {30'd0, bus.o_if_ack, bus.o_d_ack}, 32'd0);
        chk("rw no stb", 32'(bus.o_wb_stb), 32'd0);
        chk("rw d_data", bus.o_d_data, 32'hFFFF_FFFF);
        tick();
        chk("rw still no ack", {30'd0, bus.o_if_ack, bus.o_d_ack}, 32'd0);
        bus.i_if_stb = 1'b1;
        bus.i_if_addr = 32'h800;
        tick();
        bus.i_if_stb = 1'b0;
        serve("rw next", 1'b0, 32'h800, 1'b0, 3'b010, 32'h8888_0000, w);
        tick();
        tick();

        chk("total if acks", 32'(if_acks), 32'd8);
        chk("total d acks", 32'(d_acks), 32'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
